// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-register taps in, forwarding selects and stall/flush controls out
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, regwrite_m, regwrite_w, pc_src_e, mdu_start_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output load_e, regwrite_m, regwrite_w, pc_src_e, mdu_start_e,
    input  forward_a_e, forward_b_e,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done,
    input  stall_cnt
  );
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  load_e, regwrite_m, regwrite_w, pc_src_e, mdu_start_e,
    output forward_a_e, forward_b_e,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done,
    output stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch/MDU stall and flush, saturating stall counter
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int CW = $clog2(MDU_LAT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic lwstall, mdu_stall, mdu_done, stall;
  assign hz.forward_a_e = (hz.regwrite_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs1_e) ? 2'b10 :
                          (hz.regwrite_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs1_e) ? 2'b01 : 2'b00;
  assign hz.forward_b_e = (hz.regwrite_m && hz.rd_m != 5'd0 && hz.rd_m == hz.rs2_e) ? 2'b10 :
                          (hz.regwrite_w && hz.rd_w != 5'd0 && hz.rd_w == hz.rs2_e) ? 2'b01 : 2'b00;
  assign lwstall = hz.load_e && hz.rd_e != 5'd0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
  // The last BUSY cycle ignores mdu_start_e so a held level cannot retrigger the same op
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    mdu_stall = 1'b0;
    mdu_done = 1'b0;
    if (state == IDLE) begin
      mdu_stall = hz.mdu_start_e && !hz.pc_src_e;
      state_nx = mdu_stall ? BUSY : IDLE;
      cnt_nx = mdu_stall ? CW'(MDU_LAT - 2) : cnt;
    end else begin
      mdu_stall = cnt != '0;
      mdu_done = cnt == '0;
      state_nx = mdu_done ? IDLE : BUSY;
      cnt_nx = mdu_done ? cnt : cnt - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  assign stall = lwstall || mdu_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.stall_e = mdu_stall;
  assign hz.flush_d = hz.pc_src_e;
  assign hz.flush_e = lwstall || hz.pc_src_e;
  assign hz.flush_m = mdu_stall;
  assign hz.mdu_done = mdu_done;
  assign hz.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized cycles against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int LAT = 4;
  logic clk, rst_n;
  int tests, fails;
  hazard_ctrl_if #(.CNT_W(32)) hz ();
  hazard_ctrl_if #(.CNT_W(4)) hz4 ();
  hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .hz(hz4));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Reference model: 'left' counts how many Execute cycles the current MDU op still owns
  int left;
  logic [31:0] cnt_m;
  logic [1:0] exp_fa, exp_fb;
  logic exp_lw, exp_ms, exp_done, exp_sf;
  always_comb begin
    exp_fa = 2'b00;
    if (hz.regwrite_w && hz.rd_w != 0 && hz.rd_w == hz.rs1_e) exp_fa = 2'b01;
    if (hz.regwrite_m && hz.rd_m != 0 && hz.rd_m == hz.rs1_e) exp_fa = 2'b10;
    exp_fb = 2'b00;
    if (hz.regwrite_w && hz.rd_w != 0 && hz.rd_w == hz.rs2_e) exp_fb = 2'b01;
    if (hz.regwrite_m && hz.rd_m != 0 && hz.rd_m == hz.rs2_e) exp_fb = 2'b10;
    exp_lw = hz.load_e && hz.rd_e != 0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    exp_ms = (left == 0) ? (hz.mdu_start_e && !hz.pc_src_e) : (left > 1);
    exp_done = left == 1;
    exp_sf = exp_lw || exp_ms;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left <= 0;
      cnt_m <= 0;
    end else begin
      left <= (left == 0) ? (exp_ms ? LAT - 1 : 0) : left - 1;
      if (exp_sf && cnt_m != 32'hFFFF_FFFF) cnt_m <= cnt_m + 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {hz.rs1_d, hz.rs2_d, hz.rs1_e, hz.rs2_e, hz.rd_e, hz.rd_m, hz.rd_w} = '0;
    {hz.load_e, hz.regwrite_m, hz.regwrite_w, hz.pc_src_e, hz.mdu_start_e} = '0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    {hz4.rs1_d, hz4.rs2_d, hz4.rs1_e, hz4.rs2_e, hz4.rd_e, hz4.rd_m, hz4.rd_w} = '0;
    {hz4.load_e, hz4.regwrite_m, hz4.regwrite_w, hz4.pc_src_e, hz4.mdu_start_e} = '0;
    #12;
    tests++;
    if (hz.stall_cnt !== 32'd0 || hz.mdu_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: stall_cnt=%0h mdu_done=%b expected 0/0", hz.stall_cnt, hz.mdu_done);
    end
    tests++;
    if ({hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (hz.stall_cnt !== 32'd0 || hz.mdu_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: stall_cnt=%0h mdu_done=%b expected 0/0", hz.stall_cnt, hz.mdu_done);
    end
  endtask
  task automatic test_forwarding();
    idle_inputs();
    hz.rs1_e = 5; hz.rd_m = 5; hz.regwrite_m = 1; hz.rd_w = 5; hz.regwrite_w = 1;
    #1;
    tests++;
    if (hz.forward_a_e !== 2'b10) begin
      fails++;
      $display("FAIL fwd_mem_priority: got %b expected 10", hz.forward_a_e);
    end
    hz.regwrite_m = 0;
    #1;
    tests++;
    if (hz.forward_a_e !== 2'b01) begin
      fails++;
      $display("FAIL fwd_wb: got %b expected 01", hz.forward_a_e);
    end
    hz.rs1_e = 0; hz.rd_m = 0; hz.regwrite_m = 1; hz.rd_w = 0;
    #1;
    tests++;
    if (hz.forward_a_e !== 2'b00) begin
      fails++;
      $display("FAIL fwd_x0: got %b expected 00", hz.forward_a_e);
    end
    hz.rs2_e = 9; hz.rd_m = 9; hz.rd_w = 9; hz.regwrite_m = 0; hz.regwrite_w = 1;
    #1;
    tests++;
    if (hz.forward_b_e !== 2'b01 || hz.forward_a_e !== 2'b00) begin
      fails++;
      $display("FAIL fwd_b_wb: got b=%b a=%b expected 01/00", hz.forward_b_e, hz.forward_a_e);
    end
    idle_inputs();
  endtask
  task automatic test_load_use();
    logic [31:0] c0;
    idle_inputs();
    tick();
    hz.load_e = 1; hz.rd_e = 7; hz.rs2_d = 7;
    #1;
    c0 = hz.stall_cnt;
    tests++;
    if ({hz.stall_f, hz.stall_d, hz.flush_e, hz.stall_e, hz.flush_d} !== 5'b11100) begin
      fails++;
      $display("FAIL load_use: got %b expected 11100",
               {hz.stall_f, hz.stall_d, hz.flush_e, hz.stall_e, hz.flush_d});
    end
    tick();
    hz.load_e = 0;
    #1;
    tests++;
    if (hz.stall_cnt !== c0 + 1 || hz.stall_f !== 1'b0) begin
      fails++;
      $display("FAIL load_use_cnt: got cnt=%0d stall_f=%b expected %0d/0", hz.stall_cnt, hz.stall_f, c0 + 1);
    end
    hz.load_e = 1; hz.rd_e = 0; hz.rs2_d = 0;
    #1;
    tests++;
    if (hz.stall_f !== 1'b0 || hz.flush_e !== 1'b0) begin
      fails++;
      $display("FAIL load_x0: got stall_f=%b flush_e=%b expected 0/0", hz.stall_f, hz.flush_e);
    end
    idle_inputs();
  endtask
  task automatic test_branch();
    idle_inputs();
    tick();
    hz.pc_src_e = 1;
    #1;
    tests++;
    if ({hz.flush_d, hz.flush_e, hz.stall_e} !== 3'b110) begin
      fails++;
      $display("FAIL branch_flush: got %b expected 110", {hz.flush_d, hz.flush_e, hz.stall_e});
    end
    hz.mdu_start_e = 1;
    hz.load_e = 1; hz.rd_e = 3; hz.rs1_d = 3;
    #1;
    tests++;
    if ({hz.stall_d, hz.flush_d, hz.stall_e, hz.flush_m} !== 4'b1100) begin
      fails++;
      $display("FAIL branch_conflict: got %b expected 1100", {hz.stall_d, hz.flush_d, hz.stall_e, hz.flush_m});
    end
    hz.load_e = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (hz.mdu_done !== 1'b0 || hz.stall_e !== 1'b0) begin
        fails++;
        $display("FAIL branch_mdu_idle: cyc %0d done=%b stall_e=%b expected 0/0", i, hz.mdu_done, hz.stall_e);
      end
    end
    idle_inputs();
    tick();
    tests++;
    if (hz.mdu_done !== 1'b0) begin
      fails++;
      $display("FAIL branch_no_done: got %b expected 0", hz.mdu_done);
    end
  endtask
  task automatic mdu_sequence(input string name);
    logic [31:0] c0;
    c0 = hz.stall_cnt;
    for (int i = 0; i < LAT - 1; i++) begin
      tests++;
      if ({hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_m, hz.mdu_done} !== 5'b11110) begin
        fails++;
        $display("FAIL %s_busy: cyc %0d got %b expected 11110", name, i,
                 {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_m, hz.mdu_done});
      end
      tick();
    end
    tests++;
    if ({hz.stall_f, hz.stall_e, hz.flush_m, hz.mdu_done} !== 4'b0001 || hz.stall_cnt !== c0 + LAT - 1) begin
      fails++;
      $display("FAIL %s_done: got %b cnt=%0d expected 0001 cnt=%0d", name,
               {hz.stall_f, hz.stall_e, hz.flush_m, hz.mdu_done}, hz.stall_cnt, c0 + LAT - 1);
    end
    tick();
  endtask
  task automatic test_mdu();
    idle_inputs();
    tick();
    hz.mdu_start_e = 1;
    #1;
    mdu_sequence("mdu");
  endtask
  task automatic test_back_to_back();
    mdu_sequence("b2b");
    hz.mdu_start_e = 0;
    #1;
    tests++;
    if (hz.stall_e !== 1'b0 || hz.mdu_done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: stall_e=%b done=%b expected 0/0", hz.stall_e, hz.mdu_done);
    end
  endtask
  task automatic test_reset_mid_op();
    idle_inputs();
    tick();
    hz.mdu_start_e = 1;
    tick();
    rst_n = 1'b0;
    hz.mdu_start_e = 0;
    #1;
    tests++;
    if ({hz.stall_f, hz.stall_e, hz.flush_m, hz.mdu_done} !== 4'b0 || hz.stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_op: got %b cnt=%0d expected 0000 cnt=0",
               {hz.stall_f, hz.stall_e, hz.flush_m, hz.mdu_done}, hz.stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (hz.mdu_done !== 1'b0 || hz.stall_e !== 1'b0) begin
        fails++;
        $display("FAIL reset_stays_idle: cyc %0d done=%b stall_e=%b expected 0/0", i, hz.mdu_done, hz.stall_e);
      end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick();
      hz.rs1_d = 5'($urandom_range(0, 3)); hz.rs2_d = 5'($urandom_range(0, 3));
      hz.rs1_e = 5'($urandom_range(0, 3)); hz.rs2_e = 5'($urandom_range(0, 3));
      hz.rd_e = 5'($urandom_range(0, 3)); hz.rd_m = 5'($urandom_range(0, 3));
      hz.rd_w = 5'($urandom_range(0, 3));
      hz.load_e = 1'($urandom_range(0, 1)); hz.regwrite_m = 1'($urandom_range(0, 1));
      hz.regwrite_w = 1'($urandom_range(0, 1));
      hz.pc_src_e = $urandom_range(0, 7) == 0;
      hz.mdu_start_e = $urandom_range(0, 2) == 0;
      #2;
      tests++;
      if (hz.forward_a_e !== exp_fa || hz.forward_b_e !== exp_fb) begin
        fails++;
        $display("FAIL rnd_fwd: cyc %0d got %b/%b expected %b/%b", n, hz.forward_a_e, hz.forward_b_e, exp_fa, exp_fb);
      end
      tests++;
      if ({hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m, hz.mdu_done} !==
          {exp_sf, exp_sf, exp_ms, hz.pc_src_e, exp_lw || hz.pc_src_e, exp_ms, exp_done}) begin
        fails++;
        $display("FAIL rnd_ctrl: cyc %0d got %b expected %b", n,
                 {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m, hz.mdu_done},
                 {exp_sf, exp_sf, exp_ms, hz.pc_src_e, exp_lw || hz.pc_src_e, exp_ms, exp_done});
      end
      tests++;
      if (hz.stall_cnt !== cnt_m) begin
        fails++;
        $display("FAIL rnd_cnt: cyc %0d got %0d expected %0d", n, hz.stall_cnt, cnt_m);
      end
    end
    idle_inputs();
  endtask
  task automatic test_saturation();
    hz4.load_e = 1; hz4.rd_e = 3; hz4.rs1_d = 3;
    for (int i = 1; i <= 20; i++) begin
      tick();
      tests++;
      if (hz4.stall_cnt !== 4'((i > 15) ? 15 : i) || hz4.stall_f !== 1'b1) begin
        fails++;
        $display("FAIL saturation: edge %0d got cnt=%0d stall_f=%b expected %0d/1", i, hz4.stall_cnt,
                 hz4.stall_f, (i > 15) ? 15 : i);
      end
    end
    hz4.load_e = 0;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mdu();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage RISC-V core.
- It drives the select lines of the operand-forwarding muxes in Execute.
- It generates stall and flush for load-use hazards, taken branches and multi-cycle multiply/divide (MDU) ops, and keeps a saturating stall-cycle counter.
- It sits beside the datapath, taking register indices and control bits from the D/E/M/W pipeline registers.

## Interface
- MDU_LAT, 4: cycles an MDU op occupies Execute; legal range 2..64.
- CNT_W, 32: width of the stall-cycle counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  5 each  source register indices in Decode.
- rs1_e, rs2_e  in  5 each  source register indices in Execute.
- rd_e, rd_m, rd_w  in  5 each  destination register indices in Execute, Memory and Writeback.
- load_e  in  1  the instruction in Execute is a load.
- regwrite_m, regwrite_w  in  1 each  the instruction in Memory / Writeback writes the register file.
- pc_src_e  in  1  taken branch or jump resolved in Execute.
- mdu_start_e  in  1  the instruction in Execute is an MDU op (level, not pulse).
- forward_a_e, forward_b_e  out  2 each  select codes: 00 register file, 10 Memory result, 01 Writeback result.
- stall_f, stall_d, stall_e  out  1 each  hold the PC register, the F/D register and the D/E register.
- flush_d, flush_e, flush_m  out  1 each  clear the F/D, D/E and E/M registers.
- mdu_done  out  1  last Execute cycle of an MDU op.
- stall_cnt  out  CNT_W  number of cycles with stall_f=1.

## Operation
- Forwarding (combinational), same rule for A/rs1_e and B/rs2_e:
  - 10 if regwrite_m, rd_m!=0 and rd_m==rs.
  - otherwise 01 if regwrite_w, rd_w!=0 and rd_w==rs.
  - otherwise 00.
  - Memory has priority over Writeback.
- Load-use: lwstall = load_e and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
- MDU FSM, states IDLE and BUSY, down-counter cnt of width clog2(MDU_LAT):
  - IDLE: mdu_stall = mdu_start_e and not pc_src_e. When mdu_stall=1, go to BUSY with cnt = MDU_LAT-2.
  - BUSY, cnt!=0: mdu_stall=1, cnt decrements.
  - BUSY, cnt==0: mdu_stall=0, mdu_done=1, next state IDLE. mdu_start_e is ignored in this cycle, so the same op does not retrigger.
- Outputs:
  - stall_f = stall_d = lwstall or mdu_stall.
  - stall_e = mdu_stall.
  - flush_d = pc_src_e.
  - flush_e = lwstall or pc_src_e.
  - flush_m = mdu_stall.
  - mdu_done is 1 only in the BUSY cnt==0 state.
- Conflicts:
  - mdu_start_e and pc_src_e together: pc_src_e wins and the FSM stays IDLE.
  - lwstall and pc_src_e together: both stall_d and flush_d are 1; the flush takes effect.
- stall_cnt:
  - Increments by 1 on each rising edge where stall_f=1.
  - Saturates at 2^CNT_W-1 and never wraps.

## Timing
- Forwarding selects, stalls and flushes are combinational from the current-cycle inputs and FSM state. There are no registered delays on these paths.
- Load-use stall lasts exactly 1 cycle; the bubble enters Execute on the same edge.
- MDU op that enters Execute in cycle T:
  - stall_f, stall_d, stall_e and flush_m are 1 in cycles T..T+MDU_LAT-2.
  - mdu_done=1 in cycle T+MDU_LAT-1.
  - The op leaves Execute at the end of cycle T+MDU_LAT-1.
  - Total stall is MDU_LAT-1 cycles.
- A back-to-back MDU op that reaches Execute in cycle T+MDU_LAT starts a new sequence with no gap.
- Reset values, while rst_n=0 and immediately after release:
  - State is IDLE, cnt=0, stall_cnt=0, mdu_done=0.
  - Registered-state-derived outputs are 0; forwarding and stall outputs follow the inputs.
  - Asserting rst_n mid-MDU aborts the sequence immediately; mdu_done does not pulse.

## Test plan
- Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> forward_a_e=10. Drop regwrite_m -> 01. Set rs1_e=0 with rd_m=0 -> 00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle and stall_cnt increments by 1. Repeat with rd_e=0 -> no stall.
- Branch flush: pc_src_e=1 -> flush_d=flush_e=1 and stall_e=0. Add mdu_start_e=1 in the same cycle -> FSM stays IDLE and mdu_done never pulses.
- MDU, MDU_LAT=4, mdu_start_e held from cycle T:
  - stall_e=flush_m=1 in T..T+2.
  - mdu_done=1 in T+3.
  - stall_cnt=3 afterwards.
  - A second op in T+4 repeats the pattern.
- Reset mid-op: rst_n low during T+1 of an MDU sequence -> all stalls 0 and stall_cnt=0 immediately; after release with mdu_start_e=0, FSM stays IDLE.
- Saturation: CNT_W=4, continuous load-use stall for 20 cycles -> stall_cnt holds at 15.
